// File: rtl/mem_if_defs.sv
// ---------------------------------------------------------------------------
// mem_if_defs
//   Shared definitions for the datapath memory responder: data word width
//   and the responder FSM state encoding.
// ---------------------------------------------------------------------------
package mem_if_defs;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// ---------------------------------------------------------------------------
// mem_bus_responder_if
//   Request/ready memory bus between the datapath/controller (master) and
//   the memory responder (slave).
//   MAR_in   byte address (bit 0 ignored)     M_wdata  write data
//   MEM_RD   read request level               MEM_WR   write request level
//   M_rdata  read data, 0 when not valid      MEM_RDY  transfer complete
//   MEM_ERR  qualifies MEM_RDY (miss/conflict) MEM_BUSY responder not idle
// ---------------------------------------------------------------------------
interface mem_bus_responder_if
   import mem_if_defs::*;
   ();

   logic [15:0]       MAR_in;
   logic [WORD_W-1:0] M_wdata;
   logic              MEM_RD;
   logic              MEM_WR;
   logic [WORD_W-1:0] M_rdata;
   logic              MEM_RDY;
   logic              MEM_ERR;
   logic              MEM_BUSY;

   modport master (
      output MAR_in, M_wdata, MEM_RD, MEM_WR,
      input  M_rdata, MEM_RDY, MEM_ERR, MEM_BUSY
   );

   modport slave (
      input  MAR_in, M_wdata, MEM_RD, MEM_WR,
      output M_rdata, MEM_RDY, MEM_ERR, MEM_BUSY
   );

endinterface

// File: rtl/mem_word_ram.sv
// ---------------------------------------------------------------------------
// mem_word_ram
//   Single-port word RAM, synchronous write, registered read. Contents are
//   never cleared.
//   clk    clock            en     access enable for this edge
//   we     write enable     addr   word index
//   wdata  write data       rdata  registered read data (old contents on write)
// ---------------------------------------------------------------------------
module mem_word_ram #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
//   Memory-side responder for the datapath memory interface. Accepts one
//   word read or write per four-phase handshake, inserts WAIT_STATES cycles,
//   then raises MEM_RDY (with MEM_ERR on decode miss or RD&WR conflict) and
//   holds it until the request drops.
//   CLK   system clock, rising edge
//   CLR   asynchronous reset, active-high
//   bus   slave side of mem_bus_responder_if
// ---------------------------------------------------------------------------
module mem_bus_responder
   import mem_if_defs::*;
#(
   parameter int unsigned ADDR_W      = 11,
   parameter logic [15:0] BASE_ADDR   = 16'hF000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                CLK,
   input  logic                CLR,
   mem_bus_responder_if.slave  bus
);

   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
   localparam bit         NO_WAIT = (WAIT_STATES == 0);

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] lat_idx;
   logic [WORD_W-1:0] lat_wdata;
   logic              lat_wr;
   logic              lat_hit;
   logic              rdy_q;
   logic              err_q;
   logic              busy_q;
   logic              rd_valid_q;

   logic              live_hit;
   logic [ADDR_W-1:0] live_idx;
   logic              single_req;
   logic              unused_mar_bit0;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_idx;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata;

   assign live_hit        = (bus.MAR_in[15:ADDR_W+1] == BASE_ADDR[15:ADDR_W+1]);
   assign live_idx        = bus.MAR_in[ADDR_W:1];
   assign single_req      = bus.MEM_RD ^ bus.MEM_WR;
   assign unused_mar_bit0 = bus.MAR_in[0];

   // The RAM is touched only on the edge that enters ACK. With no wait
   // states that is the accept edge itself, so the live bus is used instead
   // of the latched copies. CLR gates the enable so a write cannot land while
   // the FSM is held in reset.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_idx   = lat_idx;
      ram_wdata = lat_wdata;
      if (!CLR) begin
         case (state)
            ST_IDLE: begin
               if (NO_WAIT && single_req && live_hit) begin
                  ram_en    = 1'b1;
                  ram_we    = bus.MEM_WR;
                  ram_idx   = live_idx;
                  ram_wdata = bus.M_wdata;
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd1 && lat_hit) begin
                  ram_en = 1'b1;
                  ram_we = lat_wr;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat_idx    <= '0;
         lat_wdata  <= '0;
         lat_wr     <= 1'b0;
         lat_hit    <= 1'b0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (single_req) begin
                  lat_idx   <= live_idx;
                  lat_wdata <= bus.M_wdata;
                  lat_wr    <= bus.MEM_WR;
                  lat_hit   <= live_hit;
                  cnt       <= WS_LOAD;
                  busy_q    <= 1'b1;
                  if (NO_WAIT) begin
                     state      <= ST_ACK;
                     rdy_q      <= 1'b1;
                     err_q      <= !live_hit;
                     rd_valid_q <= bus.MEM_RD && live_hit;
                  end else begin
                     state <= ST_WAIT;
                  end
               end else if (bus.MEM_RD && bus.MEM_WR) begin
                  state      <= ST_ACK;
                  rdy_q      <= 1'b1;
                  err_q      <= 1'b1;
                  rd_valid_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state      <= ST_ACK;
                  rdy_q      <= 1'b1;
                  err_q      <= !lat_hit;
                  rd_valid_q <= !lat_wr && lat_hit;
               end
            end
            ST_ACK: begin
               // Held request keeps us here, so a long write commits once.
               if (!(bus.MEM_RD || bus.MEM_WR)) begin
                  state      <= ST_IDLE;
                  rdy_q      <= 1'b0;
                  err_q      <= 1'b0;
                  rd_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   mem_word_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (WORD_W)
   ) u_ram (
      .clk   (CLK),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_idx),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.M_rdata  = ram_rdata & {WORD_W{rd_valid_q}};
   assign bus.MEM_RDY  = rdy_q;
   assign bus.MEM_ERR  = err_q;
   assign bus.MEM_BUSY = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
//   Directed bench for mem_bus_responder. Three instances share CLK/CLR:
//   index 0 -> WAIT_STATES=1, index 1 -> WAIT_STATES=3, index 2 -> 0.
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

   logic        CLK;
   logic        CLR;

   logic [15:0] mar_d   [3];
   logic [15:0] wd_d    [3];
   logic        rd_d    [3];
   logic        wr_d    [3];
   logic [15:0] rdata_o [3];
   logic        rdy_o   [3];
   logic        err_o   [3];
   logic        busy_o  [3];

   int n_err = 0;
   int n_chk = 0;

   mem_bus_responder_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : dut_g
      localparam int unsigned WS_G = (g == 0) ? 1 : (g == 1) ? 3 : 0;

      assign bus[g].MAR_in  = mar_d[g];
      assign bus[g].M_wdata = wd_d[g];
      assign bus[g].MEM_RD  = rd_d[g];
      assign bus[g].MEM_WR  = wr_d[g];
      assign rdata_o[g]     = bus[g].M_rdata;
      assign rdy_o[g]       = bus[g].MEM_RDY;
      assign err_o[g]       = bus[g].MEM_ERR;
      assign busy_o[g]      = bus[g].MEM_BUSY;

      mem_bus_responder #(
         .ADDR_W      (11),
         .BASE_ADDR   (16'hF000),
         .WAIT_STATES (WS_G)
      ) u_dut (
         .CLK (CLK),
         .CLR (CLR),
         .bus (bus[g])
      );
   end

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts #1 after a rising edge. Drives one request, waits for MEM_RDY,
   // scrambles address/data after acceptance, holds for 'hold' cycles, then
   // drops the request and checks the return to idle.
   task automatic xfer(input int d, input string tag, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd, input int hold,
                       input int exp_lat, input logic exp_err, input logic [15:0] exp_rdata);
      int   lat;
      logic got;
      lat      = 0;
      got      = 1'b0;
      mar_d[d] = a;
      wd_d[d]  = wd;
      rd_d[d]  = rd;
      wr_d[d]  = wr;
      while (!got && lat < 40) begin
         @(posedge CLK);
         #1;
         lat++;
         if (rdy_o[d]) got = 1'b1;
         if (lat == 1) begin
            mar_d[d] = ~a;
            wd_d[d]  = ~wd;
         end
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " err"},     32'(err_o[d]), 32'(exp_err));
      chk({tag, " rdata"},   32'(rdata_o[d]), 32'(exp_rdata));
      chk({tag, " busy"},    32'(busy_o[d]), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK);
         #1;
         chk({tag, " held rdy"},   32'(rdy_o[d]), 32'd1);
         chk({tag, " held busy"},  32'(busy_o[d]), 32'd1);
         chk({tag, " held rdata"}, 32'(rdata_o[d]), 32'(exp_rdata));
      end
      rd_d[d] = 1'b0;
      wr_d[d] = 1'b0;
      @(posedge CLK);
      #1;
      chk({tag, " drop rdy"},  32'(rdy_o[d]), 32'd0);
      chk({tag, " drop busy"}, 32'(busy_o[d]), 32'd0);
      chk({tag, " drop rdata"}, 32'(rdata_o[d]), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         mar_d[i] = '0;
         wd_d[i]  = '0;
         rd_d[i]  = 1'b0;
         wr_d[i]  = 1'b0;
      end
      CLR = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset rdy",   32'(rdy_o[i]), 32'd0);
         chk("reset err",   32'(err_o[i]), 32'd0);
         chk("reset busy",  32'(busy_o[i]), 32'd0);
         chk("reset rdata", 32'(rdata_o[i]), 32'd0);
      end
      CLR = 1'b0;
      @(posedge CLK);
      #1;

      // 1: write then read, one wait state
      xfer(0, "t1 wr F800", 1'b0, 1'b1, 16'hF800, 16'h1234, 0, 2, 1'b0, 16'h0000);
      xfer(0, "t1 rd F800", 1'b1, 1'b0, 16'hF800, 16'h0000, 2, 2, 1'b0, 16'h1234);

      // 2: decode misses; F0C0 is the in-window alias of 00C0
      xfer(0, "t2 rd 0080 miss", 1'b1, 1'b0, 16'h0080, 16'h0000, 0, 2, 1'b1, 16'h0000);
      xfer(0, "t2 wr F0C0",      1'b0, 1'b1, 16'hF0C0, 16'h5A5A, 0, 2, 1'b0, 16'h0000);
      xfer(0, "t2 wr 00C0 miss", 1'b0, 1'b1, 16'h00C0, 16'h0F0F, 0, 2, 1'b1, 16'h0000);
      xfer(0, "t2 rd F0C0",      1'b1, 1'b0, 16'hF0C0, 16'h0000, 0, 2, 1'b0, 16'h5A5A);

      // 3: held write; data scrambled during the hold must not be stored
      xfer(0, "t3 wr F802 held", 1'b0, 1'b1, 16'hF802, 16'hAAAA, 5, 2, 1'b0, 16'h0000);
      xfer(0, "t3 rd F802",      1'b1, 1'b0, 16'hF802, 16'h0000, 0, 2, 1'b0, 16'hAAAA);

      // 4: RD&WR conflict goes straight to ACK with error
      xfer(0, "t4 wr F804",       1'b0, 1'b1, 16'hF804, 16'h4444, 0, 2, 1'b0, 16'h0000);
      xfer(0, "t4 conflict F804", 1'b1, 1'b1, 16'hF804, 16'h9999, 0, 1, 1'b1, 16'h0000);
      xfer(0, "t4 rd F804",       1'b1, 1'b0, 16'hF804, 16'h0000, 0, 2, 1'b0, 16'h4444);

      // 5: reset during the second wait cycle, three wait states
      xfer(1, "t5 wr F806 old", 1'b0, 1'b1, 16'hF806, 16'h1111, 0, 4, 1'b0, 16'h0000);
      mar_d[1] = 16'hF806;
      wd_d[1]  = 16'h2222;
      wr_d[1]  = 1'b1;
      @(posedge CLK);
      #1;
      chk("t5 busy after accept", 32'(busy_o[1]), 32'd1);
      @(posedge CLK);
      #1;
      chk("t5 busy 2nd wait", 32'(busy_o[1]), 32'd1);
      chk("t5 rdy 2nd wait",  32'(rdy_o[1]), 32'd0);
      CLR = 1'b1;
      #1;
      chk("t5 clr rdy",   32'(rdy_o[1]), 32'd0);
      chk("t5 clr err",   32'(err_o[1]), 32'd0);
      chk("t5 clr busy",  32'(busy_o[1]), 32'd0);
      chk("t5 clr rdata", 32'(rdata_o[1]), 32'd0);
      wr_d[1] = 1'b0;
      @(posedge CLK);
      #2;
      CLR = 1'b0;
      @(posedge CLK);
      #1;
      chk("t5 idle after clr", 32'(busy_o[1]), 32'd0);
      xfer(1, "t5 rd F806", 1'b1, 1'b0, 16'hF806, 16'h0000, 0, 4, 1'b0, 16'h1111);

      // 6: zero wait states, boundary words of the window
      xfer(2, "t6 wr F000", 1'b0, 1'b1, 16'hF000, 16'hC0DE, 0, 1, 1'b0, 16'h0000);
      xfer(2, "t6 wr FFFE", 1'b0, 1'b1, 16'hFFFE, 16'hFEED, 0, 1, 1'b0, 16'h0000);
      xfer(2, "t6 rd F000", 1'b1, 1'b0, 16'hF000, 16'h0000, 0, 1, 1'b0, 16'hC0DE);
      xfer(2, "t6 rd FFFE", 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1, 1, 1'b0, 16'hFEED);
      xfer(2, "t6 rd EFFE miss", 1'b1, 1'b0, 16'hEFFE, 16'h0000, 0, 1, 1'b1, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
